// File: rtl/sys_defs.sv
// ---------------------------------------------------------------------------
// sys_defs
//
// Purpose:
//   Shared system-wide definitions for the memory side of the processor:
//   the address width, the bus command encodings used between the caches
//   and the memory controller, and the owner encoding used by the memory
//   arbiter to remember which cache issued each outstanding memory tag.
//
// Contents:
//   XLEN          - address width in bits
//   NUM_MEM_TAGS  - number of memory tags (tag 0 means "no tag")
//   MEM_TAG_W     - width of a memory tag
//   BUS_COMMAND   - BUS_NONE / BUS_LOAD / BUS_STORE
//   MEM_OWNER     - OWNER_ICACHE / OWNER_DCACHE
// ---------------------------------------------------------------------------
package sys_defs;

    localparam int XLEN         = 32;
    localparam int NUM_MEM_TAGS = 16;
    localparam int MEM_TAG_W    = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic {
        OWNER_ICACHE = 1'b0,
        OWNER_DCACHE = 1'b1
    } MEM_OWNER;

endpackage

// File: rtl/mem_tag_table.sv
// ---------------------------------------------------------------------------
// mem_tag_table
//
// Purpose:
//   Owner register file for the memory tags handed out by the controller.
//   Each of the 16 entries holds {valid, owner}. Entry 0 is never written,
//   because tag 0 means "no tag" on the memory interface.
//
// Ports:
//   clock        in   system clock
//   reset        in   asynchronous, active-low reset; clears all entries
//   set_en       in   record a newly accepted tag this cycle
//   set_tag      in   tag to record
//   set_owner    in   requester that owns set_tag
//   clr_en       in   retire a completed tag this cycle
//   clr_tag      in   tag to retire
//   lookup_tag   in   tag whose owner is being looked up (completion tag)
//   lookup_valid out  lookup_tag currently has an owner
//   lookup_owner out  owner of lookup_tag
//   outstanding  out  number of valid entries (0..15)
// ---------------------------------------------------------------------------
module mem_tag_table
    import sys_defs::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 set_en,
    input  logic [MEM_TAG_W-1:0] set_tag,
    input  MEM_OWNER             set_owner,
    input  logic                 clr_en,
    input  logic [MEM_TAG_W-1:0] clr_tag,
    input  logic [MEM_TAG_W-1:0] lookup_tag,
    output logic                 lookup_valid,
    output MEM_OWNER             lookup_owner,
    output logic [4:0]           outstanding
);

    logic [NUM_MEM_TAGS-1:0] valid_q;
    MEM_OWNER                owner_q [NUM_MEM_TAGS];

    // The clear is written before the set so that when the same tag is
    // retired and re-accepted in one cycle, the later assignment (the set)
    // is the one that takes effect.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_MEM_TAGS; i++) begin
                owner_q[i] <= OWNER_ICACHE;
            end
        end else begin
            if (clr_en && (clr_tag != '0)) begin
                valid_q[clr_tag] <= 1'b0;
            end
            if (set_en && (set_tag != '0)) begin
                valid_q[set_tag] <= 1'b1;
                owner_q[set_tag] <= set_owner;
            end
        end
    end

    // Owner lookup is combinational so completions route in the same cycle.
    always_comb begin
        lookup_valid = valid_q[lookup_tag];
        lookup_owner = owner_q[lookup_tag];
    end

    // Population count of the valid bits.
    always_comb begin
        outstanding = '0;
        for (int i = 0; i < NUM_MEM_TAGS; i++) begin
            outstanding = outstanding + {4'b0000, valid_q[i]};
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares the single memory-controller port between the instruction cache
//   and the data cache MSHR issue path. Each cycle one requester's command
//   is forwarded to memory with no added latency, the acceptance tag is
//   returned to the granted requester, and the owner of every accepted tag
//   is remembered so that completions are routed back only to that owner.
//
// Configuration:
//   MEM_ARB_STARVE_EN  defined     -> icache is promoted over dcache after
//                                     STARVE_LIMIT consecutive refused cycles
//                      not defined -> strict dcache priority, no counter
//
// Ports:
//   clock                 in   system clock
//   reset                 in   asynchronous, active-low reset
//   icache2ctlr_command   in   icache bus command
//   icache2ctlr_addr      in   icache request address
//   Ctlr2icache_response  out  icache acceptance tag (0 = not accepted)
//   Ctlr2icache_data      out  icache completion data
//   Ctlr2icache_tag       out  icache completion tag (0 = none)
//   dcache2ctlr_command   in   dcache MSHR issue command
//   dcache2ctlr_addr      in   dcache request address
//   dcache2ctlr_data      in   dcache store data
//   Ctlr2proc_response    out  dcache acceptance tag
//   Ctlr2proc_data        out  dcache completion data
//   Ctlr2proc_tag         out  dcache completion tag
//   proc2mem_command      out  command to memory
//   proc2mem_addr         out  address to memory
//   proc2mem_data         out  store data to memory
//   mem2proc_response     in   memory acceptance tag (0 = refused)
//   mem2proc_data         in   memory completion data
//   mem2proc_tag          in   memory completion tag (0 = none)
//   outstanding           out  number of tags currently owned
//   tag_err               out  sticky: a completion arrived for an unowned tag
// ---------------------------------------------------------------------------
module mem_arbiter
    import sys_defs::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clock,
    input  logic                 reset,

    input  logic [1:0]           icache2ctlr_command,
    input  logic [XLEN-1:0]      icache2ctlr_addr,
    output logic [MEM_TAG_W-1:0] Ctlr2icache_response,
    output logic [63:0]          Ctlr2icache_data,
    output logic [MEM_TAG_W-1:0] Ctlr2icache_tag,

    input  logic [1:0]           dcache2ctlr_command,
    input  logic [XLEN-1:0]      dcache2ctlr_addr,
    input  logic [63:0]          dcache2ctlr_data,
    output logic [MEM_TAG_W-1:0] Ctlr2proc_response,
    output logic [63:0]          Ctlr2proc_data,
    output logic [MEM_TAG_W-1:0] Ctlr2proc_tag,

    output logic [1:0]           proc2mem_command,
    output logic [XLEN-1:0]      proc2mem_addr,
    output logic [63:0]          proc2mem_data,
    input  logic [MEM_TAG_W-1:0] mem2proc_response,
    input  logic [63:0]          mem2proc_data,
    input  logic [MEM_TAG_W-1:0] mem2proc_tag,

    output logic [4:0]           outstanding,
    output logic                 tag_err
);

    logic     icache_req;
    logic     dcache_req;
    logic     starve_promote;
    logic     grant_icache;
    logic     grant_dcache;
    logic     accept_any;
    logic     icache_accepted;
    logic     comp_present;
    logic     comp_hit;
    logic     comp_miss;
    logic     lookup_valid;
    MEM_OWNER lookup_owner;
    MEM_OWNER set_owner;

    // Requests are masked while reset is held low so that every
    // combinational output reads as idle during reset, not only the
    // registered ones.
    always_comb begin
        icache_req = reset && (icache2ctlr_command != BUS_NONE);
        dcache_req = reset && (dcache2ctlr_command != BUS_NONE);
    end

    // dcache normally wins; icache wins when dcache is idle or when icache
    // has been refused long enough to be promoted.
    always_comb begin
        grant_icache = icache_req && (!dcache_req || starve_promote);
        grant_dcache = dcache_req && !grant_icache;
    end

    // Forward the granted requester's fields and hand the memory acceptance
    // tag back to that requester only. icache never stores, so its data
    // lane toward memory is always zero.
    always_comb begin
        proc2mem_command     = BUS_NONE;
        proc2mem_addr        = '0;
        proc2mem_data        = '0;
        Ctlr2icache_response = '0;
        Ctlr2proc_response   = '0;
        if (grant_dcache) begin
            proc2mem_command   = dcache2ctlr_command;
            proc2mem_addr      = dcache2ctlr_addr;
            proc2mem_data      = dcache2ctlr_data;
            Ctlr2proc_response = mem2proc_response;
        end else if (grant_icache) begin
            proc2mem_command     = icache2ctlr_command;
            proc2mem_addr        = icache2ctlr_addr;
            Ctlr2icache_response = mem2proc_response;
        end
    end

    // A nonzero acceptance tag is only meaningful when someone was granted.
    always_comb begin
        accept_any      = (grant_icache || grant_dcache) && (mem2proc_response != '0);
        icache_accepted = grant_icache && (mem2proc_response != '0);
        set_owner       = grant_dcache ? OWNER_DCACHE : OWNER_ICACHE;
    end

    mem_tag_table u_tag_table (
        .clock        (clock),
        .reset        (reset),
        .set_en       (accept_any),
        .set_tag      (mem2proc_response),
        .set_owner    (set_owner),
        .clr_en       (comp_hit),
        .clr_tag      (mem2proc_tag),
        .lookup_tag   (mem2proc_tag),
        .lookup_valid (lookup_valid),
        .lookup_owner (lookup_owner),
        .outstanding  (outstanding)
    );

    // A completion either hits an owned tag and is routed to its owner, or
    // misses and is dropped for both requesters while flagging an error.
    always_comb begin
        comp_present = reset && (mem2proc_tag != '0);
        comp_hit     = comp_present && lookup_valid;
        comp_miss    = comp_present && !lookup_valid;
    end

    // Completion data/tag go to exactly one requester; the other sees zeros.
    always_comb begin
        Ctlr2icache_tag  = '0;
        Ctlr2icache_data = '0;
        Ctlr2proc_tag    = '0;
        Ctlr2proc_data   = '0;
        if (comp_hit) begin
            if (lookup_owner == OWNER_DCACHE) begin
                Ctlr2proc_tag  = mem2proc_tag;
                Ctlr2proc_data = mem2proc_data;
            end else begin
                Ctlr2icache_tag  = mem2proc_tag;
                Ctlr2icache_data = mem2proc_data;
            end
        end
    end

    // Sticky error flag: once an unowned completion is seen it stays set
    // until the next reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_err <= 1'b0;
        end else if (comp_miss) begin
            tag_err <= 1'b1;
        end
    end

`ifdef MEM_ARB_STARVE_EN
    localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_cnt;

    // Counts consecutive cycles in which icache asked and was not accepted,
    // whether it lost arbitration or memory refused it. It saturates at the
    // promotion threshold, since any value at or above it behaves the same.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (icache_req && !icache_accepted) begin
            if (starve_cnt < STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    assign starve_promote = (starve_cnt >= STARVE_MAX);
`else
    // Strict dcache priority: icache is never promoted over a dcache request.
    assign starve_promote = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. A behavioural model of the arbiter
// (grant rule, owner list per tag, refused-cycle count, sticky error) is
// evaluated every cycle and every DUT output is compared against it, plus
// directed checks for the documented scenarios. Honours MEM_ARB_STARVE_EN.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    import sys_defs::*;

    localparam int STARVE_LIMIT = 4;
`ifdef MEM_ARB_STARVE_EN
    localparam bit STARVE_MODE = 1'b1;
`else
    localparam bit STARVE_MODE = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic [1:0]        icache2ctlr_command;
    logic [XLEN-1:0]   icache2ctlr_addr;
    logic [3:0]        Ctlr2icache_response;
    logic [63:0]       Ctlr2icache_data;
    logic [3:0]        Ctlr2icache_tag;
    logic [1:0]        dcache2ctlr_command;
    logic [XLEN-1:0]   dcache2ctlr_addr;
    logic [63:0]       dcache2ctlr_data;
    logic [3:0]        Ctlr2proc_response;
    logic [63:0]       Ctlr2proc_data;
    logic [3:0]        Ctlr2proc_tag;
    logic [1:0]        proc2mem_command;
    logic [XLEN-1:0]   proc2mem_addr;
    logic [63:0]       proc2mem_data;
    logic [3:0]        mem2proc_response;
    logic [63:0]       mem2proc_data;
    logic [3:0]        mem2proc_tag;
    logic [4:0]        outstanding;
    logic              tag_err;

    // Reference model state
    bit m_valid  [16];
    bit m_dcache [16];
    int m_starve;
    bit m_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clock                (clock),
        .reset                (reset),
        .icache2ctlr_command  (icache2ctlr_command),
        .icache2ctlr_addr     (icache2ctlr_addr),
        .Ctlr2icache_response (Ctlr2icache_response),
        .Ctlr2icache_data     (Ctlr2icache_data),
        .Ctlr2icache_tag      (Ctlr2icache_tag),
        .dcache2ctlr_command  (dcache2ctlr_command),
        .dcache2ctlr_addr     (dcache2ctlr_addr),
        .dcache2ctlr_data     (dcache2ctlr_data),
        .Ctlr2proc_response   (Ctlr2proc_response),
        .Ctlr2proc_data       (Ctlr2proc_data),
        .Ctlr2proc_tag        (Ctlr2proc_tag),
        .proc2mem_command     (proc2mem_command),
        .proc2mem_addr        (proc2mem_addr),
        .proc2mem_data        (proc2mem_data),
        .mem2proc_response    (mem2proc_response),
        .mem2proc_data        (mem2proc_data),
        .mem2proc_tag         (mem2proc_tag),
        .outstanding          (outstanding),
        .tag_err              (tag_err)
    );

    task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s: got %0h expected %0h", name, obs, exp);
    endtask

    function automatic int modelCount();
        int c = 0;
        for (int i = 1; i < 16; i++) c += m_valid[i] ? 1 : 0;
        return c;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i]  = 1'b0;
            m_dcache[i] = 1'b0;
        end
        m_starve = 0;
        m_err    = 1'b0;
    endfunction

    // Drive one cycle of inputs, compare all outputs with the model, then
    // advance the model to the state it will hold after the next clock edge.
    task automatic applyStimulus(input logic [1:0] ic, input logic [31:0] ia,
                                 input logic [1:0] dc, input logic [31:0] da,
                                 input logic [63:0] dd, input logic [3:0] mr,
                                 input logic [63:0] md, input logic [3:0] mt);
        bit ireq, dreq, promote, gi, gd, hit;
        logic [1:0]  e_cmd;
        logic [31:0] e_addr;
        logic [63:0] e_data, e_idata, e_ddata;
        logic [3:0]  e_iresp, e_dresp, e_itag, e_dtag;
        @(negedge clock);
        icache2ctlr_command = ic;  icache2ctlr_addr = ia;
        dcache2ctlr_command = dc;  dcache2ctlr_addr = da;  dcache2ctlr_data = dd;
        mem2proc_response   = mr;  mem2proc_data    = md;  mem2proc_tag     = mt;
        #2;
        ireq    = (ic != 2'd0);
        dreq    = (dc != 2'd0);
        promote = STARVE_MODE && (m_starve >= STARVE_LIMIT);
        gi      = ireq && (!dreq || promote);
        gd      = dreq && !gi;
        e_cmd   = gd ? dc : (gi ? ic : 2'd0);
        e_addr  = gd ? da : (gi ? ia : 32'd0);
        e_data  = gd ? dd : 64'd0;
        e_iresp = gi ? mr : 4'd0;
        e_dresp = gd ? mr : 4'd0;
        hit     = (mt != 4'd0) && m_valid[mt];
        e_itag  = (hit && !m_dcache[mt]) ? mt : 4'd0;
        e_idata = (hit && !m_dcache[mt]) ? md : 64'd0;
        e_dtag  = (hit &&  m_dcache[mt]) ? mt : 4'd0;
        e_ddata = (hit &&  m_dcache[mt]) ? md : 64'd0;
        checkOutput("cmd",   proc2mem_command,     e_cmd);
        checkOutput("addr",  proc2mem_addr,        e_addr);
        checkOutput("wdata", proc2mem_data,        e_data);
        checkOutput("iresp", Ctlr2icache_response, e_iresp);
        checkOutput("dresp", Ctlr2proc_response,   e_dresp);
        checkOutput("itag",  Ctlr2icache_tag,      e_itag);
        checkOutput("idata", Ctlr2icache_data,     e_idata);
        checkOutput("dtag",  Ctlr2proc_tag,        e_dtag);
        checkOutput("ddata", Ctlr2proc_data,       e_ddata);
        checkOutput("outstanding", outstanding,    modelCount());
        checkOutput("tag_err", tag_err,            m_err);
        if (mt != 4'd0 && !m_valid[mt]) m_err = 1'b1;
        if (hit) m_valid[mt] = 1'b0;
        if (mr != 4'd0 && (gi || gd)) begin
            m_valid[mr]  = 1'b1;
            m_dcache[mr] = gd;
        end
        if (ireq && !(gi && mr != 4'd0)) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve;
        else m_starve = 0;
    endtask

    // Assert reset at a falling edge with busy inputs; every output must go
    // idle at once, and stay idle across a clock edge.
    task automatic pulseReset();
        @(negedge clock);
        icache2ctlr_command = 2'd1;  dcache2ctlr_command = 2'd2;
        dcache2ctlr_data    = 64'hDEAD;
        mem2proc_response   = 4'd9;  mem2proc_tag = 4'd4;  mem2proc_data = 64'hBEEF;
        reset = 1'b0;
        #1;
        modelReset();
        for (int k = 0; k < 2; k++) begin
            checkOutput("rst_outstanding", outstanding,          5'd0);
            checkOutput("rst_cmd",         proc2mem_command,     2'd0);
            checkOutput("rst_addr",        proc2mem_addr,        32'd0);
            checkOutput("rst_wdata",       proc2mem_data,        64'd0);
            checkOutput("rst_iresp",       Ctlr2icache_response, 4'd0);
            checkOutput("rst_dresp",       Ctlr2proc_response,   4'd0);
            checkOutput("rst_itag",        Ctlr2icache_tag,      4'd0);
            checkOutput("rst_dtag",        Ctlr2proc_tag,        4'd0);
            checkOutput("rst_ddata",       Ctlr2proc_data,       64'd0);
            checkOutput("rst_tag_err",     tag_err,              1'b0);
            @(negedge clock);
            #1;
        end
        icache2ctlr_command = 2'd0;  dcache2ctlr_command = 2'd0;
        mem2proc_response   = 4'd0;  mem2proc_tag        = 4'd0;
        reset = 1'b1;
    endtask

    initial begin
        logic [3:0] tags [6];
        logic [3:0] ic, dc, mr, mt;
        int q[$];
        tags = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd8};

        reset = 1'b0;
        icache2ctlr_command = 2'd0; icache2ctlr_addr = '0;
        dcache2ctlr_command = 2'd0; dcache2ctlr_addr = '0; dcache2ctlr_data = '0;
        mem2proc_response = '0; mem2proc_data = '0; mem2proc_tag = '0;
        modelReset();
        #2;
        checkOutput("init_outstanding", outstanding, 5'd0);
        checkOutput("init_tag_err",     tag_err,     1'b0);
        checkOutput("init_cmd",         proc2mem_command, 2'd0);
        @(negedge clock);
        reset = 1'b1;

        $display("[TB] dcache-only load and completion");
        applyStimulus(2'd0, 32'h0, 2'd1, 32'h100, 64'h0, 4'd3, 64'h0, 4'd0);
        checkOutput("t1_dresp", Ctlr2proc_response,   4'd3);
        checkOutput("t1_iresp", Ctlr2icache_response, 4'd0);
        checkOutput("t1_addr",  proc2mem_addr,        32'h100);
        applyStimulus(2'd0, 32'h0, 2'd0, 32'h0, 64'h0, 4'd0, 64'hAA, 4'd3);
        checkOutput("t1_out1",  outstanding,     5'd1);
        checkOutput("t1_dtag",  Ctlr2proc_tag,   4'd3);
        checkOutput("t1_ddata", Ctlr2proc_data,  64'hAA);
        checkOutput("t1_itag",  Ctlr2icache_tag, 4'd0);
        applyStimulus(2'd0, 32'h0, 2'd0, 32'h0, 64'h0, 4'd0, 64'h0, 4'd0);
        checkOutput("t1_out0",  outstanding,     5'd0);

        $display("[TB] completion for a never-issued tag");
        applyStimulus(2'd0, 32'h0, 2'd0, 32'h0, 64'h0, 4'd0, 64'h77, 4'd7);
        checkOutput("t3_itag", Ctlr2icache_tag, 4'd0);
        checkOutput("t3_dtag", Ctlr2proc_tag,   4'd0);
        applyStimulus(2'd0, 32'h0, 2'd0, 32'h0, 64'h0, 4'd0, 64'h0, 4'd0);
        checkOutput("t3_err1", tag_err, 1'b1);
        applyStimulus(2'd0, 32'h0, 2'd0, 32'h0, 64'h0, 4'd0, 64'h0, 4'd0);
        checkOutput("t3_err2", tag_err, 1'b1);

        $display("[TB] both caches request every cycle");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2'd1, 32'h200, 2'd1, 32'h300, 64'h0, tags[i], 64'h0, 4'd0);
            checkOutput("t2_addr", proc2mem_addr, (STARVE_MODE && i == 4) ? 32'h200 : 32'h300);
        end

        $display("[TB] same tag accepted and completed together");
        applyStimulus(2'd0, 32'h0, 2'd1, 32'h500, 64'h0, 4'd5, 64'h0, 4'd0);
        applyStimulus(2'd1, 32'h540, 2'd0, 32'h0, 64'h0, 4'd5, 64'h55, 4'd5);
        checkOutput("t5_dtag",  Ctlr2proc_tag,        4'd5);
        checkOutput("t5_ddata", Ctlr2proc_data,       64'h55);
        checkOutput("t5_itag",  Ctlr2icache_tag,      4'd0);
        checkOutput("t5_iresp", Ctlr2icache_response, 4'd5);
        applyStimulus(2'd0, 32'h0, 2'd0, 32'h0, 64'h0, 4'd0, 64'h66, 4'd5);
        checkOutput("t5_itag2",  Ctlr2icache_tag,  4'd5);
        checkOutput("t5_idata2", Ctlr2icache_data, 64'h66);
        checkOutput("t5_dtag2",  Ctlr2proc_tag,    4'd0);

        $display("[TB] reset with three outstanding");
        for (int i = 0; i < 3; i++)
            applyStimulus(2'd0, 32'h0, 2'd0, 32'h0, 64'h0, 4'd0, 64'h10 + i, tags[i]);
        applyStimulus(2'd0, 32'h0, 2'd0, 32'h0, 64'h0, 4'd0, 64'h0, 4'd0);
        checkOutput("t6_out3", outstanding, 5'd3);
        pulseReset();
        applyStimulus(2'd0, 32'h0, 2'd0, 32'h0, 64'h0, 4'd0, 64'h44, 4'd4);
        checkOutput("t6_stale_dtag", Ctlr2proc_tag, 4'd0);
        applyStimulus(2'd0, 32'h0, 2'd0, 32'h0, 64'h0, 4'd0, 64'h0, 4'd0);
        checkOutput("t6_stale_err", tag_err, 1'b1);
        pulseReset();

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            ic = 4'($urandom_range(0, 2));
            dc = 4'($urandom_range(0, 2));
            mr = 4'd0;
            if ((ic != 0 || dc != 0) && $urandom_range(0, 3) != 0) mr = 4'($urandom_range(1, 15));
            mt = 4'd0;
            q.delete();
            for (int i = 1; i < 16; i++) if (m_valid[i]) q.push_back(i);
            if ($urandom_range(0, 19) == 0) mt = 4'($urandom_range(1, 15));
            else if (q.size() > 0 && $urandom_range(0, 1) == 1) mt = 4'(q[$urandom_range(0, q.size() - 1)]);
            applyStimulus(ic[1:0], $urandom, dc[1:0], $urandom, {$urandom, $urandom},
                          mr, {$urandom, $urandom}, mt);
        end

        $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single memory-controller port between the instruction cache and the data cache (MSHR issue path). Each cycle it selects one requester's bus command and forwards it to memory. It records which requester owns each memory tag the controller hands out, and routes the completion (tag + 64-bit data) back only to that owner. It sits between `icache`/`dcache` and the memory model and has zero added latency on the request path.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive refused icache request cycles before icache gets priority.
- `XLEN`: taken from `sys_defs`, not overridable here.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `icache2ctlr_command` in 2: BUS_NONE / BUS_LOAD / BUS_STORE.
- `icache2ctlr_addr` in XLEN: icache request address.
- `Ctlr2icache_response` in the out direction, 4: nonzero tag means this cycle's icache request was accepted.
- `Ctlr2icache_data` out 64: completion data for icache.
- `Ctlr2icache_tag` out 4: completion tag for icache; 0 means none.
- `dcache2ctlr_command` in 2: dcache MSHR issue command.
- `dcache2ctlr_addr` in XLEN: dcache request address.
- `dcache2ctlr_data` in 64: dcache store data.
- `Ctlr2proc_response` out 4: dcache acceptance tag.
- `Ctlr2proc_data` out 64: dcache completion data.
- `Ctlr2proc_tag` out 4: dcache completion tag.
- `proc2mem_command` out 2: command to memory.
- `proc2mem_addr` out XLEN: address to memory.
- `proc2mem_data` out 64: store data to memory.
- `mem2proc_response` in 4: memory acceptance tag; 0 means refused.
- `mem2proc_data` in 64: memory completion data.
- `mem2proc_tag` in 4: memory completion tag; 0 means none.
- `outstanding` out 5: count of valid owner-table entries.
- `tag_err` out 1: sticky; set when a completion arrives for an unowned tag.

## Operation
- Grant (combinational):
  - Default is dcache priority.
  - icache wins when the dcache command is BUS_NONE, or when `starve_cnt >= STARVE_LIMIT`.
  - Only a requester with a non-NONE command can be granted.
  - If neither requests, `proc2mem_command` = BUS_NONE and addr/data = 0.
- Request mux:
  - `proc2mem_*` carries the granted requester's fields.
  - icache store data is always 0.
- Acceptance routing:
  - `mem2proc_response` goes to the granted requester's response port.
  - The non-granted requester sees 0.
- Owner table: 16 entries, each {valid, owner}; entry 0 is never used.
  - On a nonzero `mem2proc_response` T: set `valid[T]=1` and `owner[T]`=granted requester, for loads and stores alike.
- Completion routing: on a nonzero `mem2proc_tag` C with `valid[C]`:
  - Drive the owner's tag port with C and its data port with `mem2proc_data`.
  - The other requester sees tag 0 and data 0.
  - Clear `valid[C]`.
- Completion for a tag with `valid[C]=0`:
  - Forward to neither requester; both see tag 0 and data 0.
  - Set `tag_err`; it stays set until reset.
- Same tag accepted and completed in the same cycle: the completion uses the old entry (clear first), then the new acceptance set is applied; the set wins.
- `outstanding` = popcount of valid entries, range 0..15.
- Starvation counter `starve_cnt` (saturating, width `$clog2(STARVE_LIMIT+1)`):
  - Increments when icache requests and is not accepted (not granted, or granted with response 0).
  - Clears when icache is accepted or icache command is BUS_NONE.

## Timing
- Request mux, grant, and acceptance/completion routing are all combinational; there is no added cycle. dcache MSHR issue sees acceptance in the same cycle.
- Owner table, `starve_cnt`, and `tag_err` update on posedge `clock`.
- Reset (asynchronous, active-low) clears the table, `starve_cnt` and `tag_err`. While in reset, outputs are:
  - `outstanding` = 0, `tag_err` = 0.
  - `proc2mem_command` = BUS_NONE, addr/data = 0.
  - All response and completion ports = 0.
- Reset mid-operation drops all in-flight ownership. Memory must be reset together with this block; completions for pre-reset tags set `tag_err`.
- One acceptance and one completion per cycle at most.

## Configuration
- `MEM_ARB_STARVE_EN` defined: starvation counter present; icache is promoted after `STARVE_LIMIT` refused cycles.
- Not defined: strict dcache priority. No counter logic; `STARVE_LIMIT` is ignored.

## Structure
- `BUS_COMMAND` encodings, `XLEN`, and a new `MEM_OWNER` enum (OWNER_ICACHE=0, OWNER_DCACHE=1) belong in `sys_defs`.
- One sub-module, `mem_tag_table`:
  - 16-entry valid/owner register file.
  - Inputs: a set port and a clear port.
  - Outputs: the owner lookup and the `outstanding` popcount.
- Grant/mux logic and the starvation counter live in the top level.

## Test plan
- Only dcache issues BUS_LOAD 0x100; memory responds 3, later completes tag 3 with data 0xAA → `Ctlr2proc_response`=3, `Ctlr2icache_response`=0; on completion `Ctlr2proc_tag`=3, data 0xAA, icache tag 0; `outstanding` goes 1→0.
- Both request every cycle, memory accepts each (with `MEM_ARB_STARVE_EN`, `STARVE_LIMIT`=4) → dcache granted 4 cycles, icache granted on the 5th, then dcache again.
- Same traffic without the macro → icache never granted while dcache requests.
- Memory returns tag 7 never issued → both completion tags 0, `tag_err`=1 and stays 1.
- Accept tag 5 for icache while tag 5 (owned by dcache) completes the same cycle → dcache receives the completion; the next completion of tag 5 routes to icache.
- Reset asserted with 3 outstanding → `outstanding`=0 immediately, `proc2mem_command`=BUS_NONE.
